// File: rtl/vector_register_file_lanes.sv
// vector_register_file_lanes
//   Vector register file for the SIMD AES datapath. It holds DEPTH registers,
//   and each register is LANES x LANE_BITS bits wide.
//   - Two combinational read ports.
//   - A lane-masked ALU write port.
//   - A full-width load-return write port.
//   - A sequenced clear engine that zeroes the whole file one register per
//     cycle, so software can clear it without a global reset.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   address1/address2 -> read1/2  combinational read ports
//   writeEn, addressw,
//   writeData, writeMask          ALU write; per-lane enable via writeMask
//   loadEn, loadAddr, loadData    load-return write; always full width
//   clearReq                      single-cycle request to start a clear
//   clearBusy                     high while the clear sequence runs
//   collision                     one-cycle pulse, raised the cycle after the
//                                 ALU and load ports wrote the same address
//
// Optional feature
//   VRF_WRITE_BYPASS_EN : when defined, the read ports forward same-cycle
//   write data while the file is idle. Per lane, ALU data has priority over
//   load data, and load data has priority over stored contents.

module vector_register_file_lanes #(
    parameter  int DEPTH     = 16,
    parameter  int LANES     = 4,
    parameter  int LANE_BITS = 32,
    localparam int VW        = LANES * LANE_BITS,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     address1,
    input  logic [AW-1:0]     address2,
    output logic [VW-1:0]     read1,
    output logic [VW-1:0]     read2,
    input  logic              writeEn,
    input  logic [AW-1:0]     addressw,
    input  logic [VW-1:0]     writeData,
    input  logic [LANES-1:0]  writeMask,
    input  logic              loadEn,
    input  logic [AW-1:0]     loadAddr,
    input  logic [VW-1:0]     loadData,
    input  logic              clearReq,
    output logic              clearBusy,
    output logic              collision
);

    // state | meaning
    // IDLE  | normal operation; both write ports are accepted
    // CLEAR | reg[cnt_q] is zeroed each edge; writes and clearReq are ignored
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            collision_q, collision_d;
    logic [VW-1:0]   mem [DEPTH];
    logic            idle;

    assign idle = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clearReq) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // DEPTH is a power of two, so the increment wraps to 0 on the
                // same edge that clears the last register.
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A collision is flagged whenever both ports hit the same register, even
    // when writeMask is zero and the load therefore wins every lane.
    assign collision_d = idle && writeEn && loadEn && (addressw == loadAddr);

    assign clearBusy = (state_q == CLEAR);
    assign collision = collision_q;

    // Where both ports target the same register, the ALU lanes named by
    // writeMask win and the load supplies the remaining lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (writeEn && (addressw == AW'(r)) && writeMask[l]) begin
                        mem[r][l*LANE_BITS +: LANE_BITS] <= writeData[l*LANE_BITS +: LANE_BITS];
                    end else if (loadEn && (loadAddr == AW'(r))) begin
                        mem[r][l*LANE_BITS +: LANE_BITS] <= loadData[l*LANE_BITS +: LANE_BITS];
                    end
                end
            end
        end
    end

`ifdef VRF_WRITE_BYPASS_EN
    always_comb begin
        read1 = mem[address1];
        read2 = mem[address2];
        if (idle) begin
            for (int l = 0; l < LANES; l++) begin
                if (writeEn && (addressw == address1) && writeMask[l]) begin
                    read1[l*LANE_BITS +: LANE_BITS] = writeData[l*LANE_BITS +: LANE_BITS];
                end else if (loadEn && (loadAddr == address1)) begin
                    read1[l*LANE_BITS +: LANE_BITS] = loadData[l*LANE_BITS +: LANE_BITS];
                end
                if (writeEn && (addressw == address2) && writeMask[l]) begin
                    read2[l*LANE_BITS +: LANE_BITS] = writeData[l*LANE_BITS +: LANE_BITS];
                end else if (loadEn && (loadAddr == address2)) begin
                    read2[l*LANE_BITS +: LANE_BITS] = loadData[l*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end
`else
    assign read1 = mem[address1];
    assign read2 = mem[address2];
`endif

endmodule

// File: tb/tb_vector_register_file_lanes.sv
module tb_vector_register_file_lanes;

    localparam int DEPTH = 16;
    localparam int LANES = 4;
    localparam int LB    = 32;
    localparam int VW    = LANES * LB;
    localparam int AW    = 4;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    address1, address2, addressw, loadAddr;
    logic [VW-1:0]    read1, read2, writeData, loadData;
    logic             writeEn, loadEn, clearReq;
    logic [LANES-1:0] writeMask;
    logic             clearBusy, collision;

    vector_register_file_lanes #(.DEPTH(DEPTH), .LANES(LANES), .LANE_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .address1(address1), .address2(address2),
        .read1(read1), .read2(read2),
        .writeEn(writeEn), .addressw(addressw),
        .writeData(writeData), .writeMask(writeMask),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
        .clearReq(clearReq), .clearBusy(clearBusy), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [VW-1:0] r1;
        logic [VW-1:0] r2;
        logic          busy;
        logic          coll;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the register contents, plus whether a clear is in
    // progress, how many registers it has zeroed so far, and the collision
    // value expected in the current cycle.
    logic [VW-1:0] mem_m [DEPTH];
    bit            busy_m;
    int            done_m;
    bit            coll_m;

    function automatic logic [VW-1:0] rd_exp(input logic [AW-1:0] a);
        logic [VW-1:0] v;
        v = mem_m[a];
`ifdef VRF_WRITE_BYPASS_EN
        if (!busy_m) begin
            for (int l = 0; l < LANES; l++) begin
                if (writeEn && addressw == a && writeMask[l])
                    v[l*LB +: LB] = writeData[l*LB +: LB];
                else if (loadEn && loadAddr == a)
                    v[l*LB +: LB] = loadData[l*LB +: LB];
            end
        end
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
        busy_m = 0;
        done_m = 0;
        coll_m = 0;
    endtask

    task automatic chk_model(input string name);
        exp_q.push_back('{name, rd_exp(address1), rd_exp(address2), busy_m, coll_m});
    endtask

    task automatic chk_lit(input string name, input logic [VW-1:0] r1, input logic busy, input logic coll);
        exp_q.push_back('{name, r1, rd_exp(address2), busy, coll});
    endtask

    // Advances one clock edge and updates the model from the inputs that were
    // applied before that edge. Afterwards the single-cycle controls return
    // to idle.
    task automatic tick();
        bit c;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            c = !busy_m && writeEn && loadEn && (addressw == loadAddr);
            if (busy_m) begin
                mem_m[done_m] = '0;
                done_m++;
                if (done_m == DEPTH) begin
                    busy_m = 0;
                    done_m = 0;
                end
            end else begin
                if (loadEn) mem_m[loadAddr] = loadData;
                if (writeEn)
                    for (int l = 0; l < LANES; l++)
                        if (writeMask[l]) mem_m[addressw][l*LB +: LB] = writeData[l*LB +: LB];
                if (clearReq) begin
                    busy_m = 1;
                    done_m = 0;
                end
            end
            coll_m = c;
        end
        #1;
        writeEn  = 0;
        loadEn   = 0;
        clearReq = 0;
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (read1 !== e.r1 || read2 !== e.r2 || clearBusy !== e.busy || collision !== e.coll) begin
                errors++;
                $display("FAIL %s: got read1=%h read2=%h busy=%b coll=%b, expected read1=%h read2=%h busy=%b coll=%b",
                         e.name, read1, read2, clearBusy, collision, e.r1, e.r2, e.busy, e.coll);
            end
        end
    end

    logic [VW-1:0] allA, allB, allC, allD, allE;

    initial begin
        allA = {VW/4{4'hA}};
        allB = {VW/4{4'hB}};
        allC = {VW/4{4'hC}};
        allD = {VW/4{4'hD}};
        allE = {VW/4{4'hE}};
        rst_n = 0;
        address1 = 0; address2 = 0; addressw = 0; loadAddr = 0;
        writeData = 0; loadData = 0; writeMask = 0;
        writeEn = 0; loadEn = 0; clearReq = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;

        // Reset state
        address1 = 3; address2 = 15;
        chk_lit("reset_read", '0, 0, 0);
        tick();

        // Masked write
        writeEn = 1; addressw = 10; writeData = allA; writeMask = 4'hF;
        tick();
        writeEn = 1; addressw = 10; writeMask = 4'b0101;
        writeData = 128'h11111111_22222222_33333333_44444444;
        tick();
        address1 = 10;
        chk_lit("masked_write", 128'hAAAAAAAA_22222222_AAAAAAAA_44444444, 0, 0);
        tick();

        // Collision on the same address
        writeEn = 1; addressw = 5; writeMask = 4'b0011; writeData = allB;
        loadEn = 1; loadAddr = 5; loadData = allC;
        tick();
        address1 = 5;
        chk_lit("collision_data", 128'hCCCCCCCC_CCCCCCCC_BBBBBBBB_BBBBBBBB, 0, 1);
        tick();
        chk_lit("collision_one_cycle", 128'hCCCCCCCC_CCCCCCCC_BBBBBBBB_BBBBBBBB, 0, 0);
        tick();

        // Collision with writeMask=0: the load wins every lane, flag still set
        writeEn = 1; addressw = 7; writeMask = 4'b0000; writeData = allB;
        loadEn = 1; loadAddr = 7; loadData = allC;
        tick();
        address1 = 7;
        chk_lit("collision_mask0", allC, 0, 1);
        tick();

        // Different addresses: both writes land, no collision
        writeEn = 1; addressw = 1; writeMask = 4'hF; writeData = allB;
        loadEn = 1; loadAddr = 12; loadData = allC;
        tick();
        address1 = 1; address2 = 12;
        chk_lit("dual_write_a1", allB, 0, 0);
        tick();
        address1 = 12;
        chk_lit("dual_write_a12", allC, 0, 0);
        tick();

        // Clear sequence
        for (int r = 0; r < DEPTH; r++) begin
            loadEn = 1; loadAddr = AW'(r); loadData = rnd_vec() | 1;
            tick();
        end
        clearReq = 1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            address1 = 6; address2 = AW'(i);
            if (i == 3) begin
                writeEn = 1; addressw = 6; writeMask = 4'hF; writeData = allD;
            end
            if (i == 8) clearReq = 1;
            chk_lit("clear_busy", rd_exp(6), 1, 0);
            tick();
        end
        for (int r = 0; r < DEPTH; r++) begin
            address1 = AW'(r); address2 = AW'(DEPTH - 1 - r);
            chk_lit("after_clear", '0, 0, 0);
            tick();
        end

        // Reset in the middle of a clear
        for (int r = 0; r < DEPTH; r++) begin
            loadEn = 1; loadAddr = AW'(r); loadData = rnd_vec() | 1;
            tick();
        end
        clearReq = 1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        rst_n = 0;
        #1;
        address1 = 15; address2 = 14;
        model_reset();
        chk_lit("reset_mid_clear", '0, 0, 0);
        tick();
        rst_n = 1;
        tick();
        writeEn = 1; addressw = 9; writeMask = 4'hF; writeData = allB;
        tick();
        address1 = 9; address2 = 15;
        chk_lit("write_after_reset", allB, 0, 0);
        tick();

        // Bypass against reg12, which is zero after the reset
        writeEn = 1; addressw = 12; address1 = 12; writeMask = 4'b1000; writeData = allE;
`ifdef VRF_WRITE_BYPASS_EN
        chk_lit("bypass_same_cycle", 128'hEEEEEEEE_00000000_00000000_00000000, 0, 0);
`else
        chk_lit("bypass_same_cycle", '0, 0, 0);
`endif
        tick();
        chk_lit("bypass_next_cycle", 128'hEEEEEEEE_00000000_00000000_00000000, 0, 0);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic narrow;
            narrow    = ($urandom_range(0, 3) == 0);
            writeEn   = $urandom_range(0, 1);
            loadEn    = $urandom_range(0, 1);
            addressw  = narrow ? AW'($urandom_range(0, 1)) : AW'($urandom);
            loadAddr  = narrow ? AW'($urandom_range(0, 1)) : AW'($urandom);
            writeMask = LANES'($urandom);
            writeData = rnd_vec();
            loadData  = rnd_vec();
            clearReq  = ($urandom_range(0, 59) == 0);
            address1  = ($urandom_range(0, 2) == 0) ? addressw : AW'($urandom);
            address2  = ($urandom_range(0, 2) == 0) ? loadAddr : AW'($urandom);
            chk_model("random");
            tick();
        end
        chk_model("random_final");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending checks, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
